// File: rtl/stopwatch_bcd.sv
// ---------------------------------------------------------------------------
// stopwatch_bcd
//   MM:SS stopwatch that counts rising edges of the divided square wave
//   (tick_clk_i) as one-second steps, producing four BCD digits for the
//   seven-segment display stage. tick_clk_i is sampled as ordinary data in
//   the clk_i domain; it never clocks any flop.
//
// Ports:
//   clk_i       in   system clock, all state updates on its rising edge
//   rst_i       in   synchronous active-high reset
//   tick_clk_i  in   divided square wave; each rising edge is one count step
//   start_i     in   one-cycle pulse, start/pause toggle
//   clear_i     in   one-cycle pulse, return to 00:00 and IDLE
//   sec_ones_o  out  BCD seconds units (0-9)
//   sec_tens_o  out  BCD seconds tens (0-SEC_TENS_MAX)
//   min_ones_o  out  BCD minutes units (0-9)
//   min_tens_o  out  BCD minutes tens (0-MIN_TENS_MAX)
//   running_o   out  high while in RUN
//   wrap_o      out  one-cycle pulse when the count rolls over to 00:00
// ---------------------------------------------------------------------------
module stopwatch_bcd #(
  parameter int unsigned MIN_TENS_MAX = 5,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_clk_i,
  input  logic       start_i,
  input  logic       clear_i,
  output logic [3:0] sec_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] min_tens_o,
  output logic       running_o,
  output logic       wrap_o
);

  localparam logic [3:0] SEC_TENS_LIM = 4'(SEC_TENS_MAX);
  localparam logic [3:0] MIN_TENS_LIM = 4'(MIN_TENS_MAX);
  localparam logic [3:0] ONES_LIM     = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       tick_q, tick_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;
  logic       tick_s;
  logic       count_s;

  // Rising-edge detect on the sampled slow wave. tick_q resets to 1 so a
  // wave that is already high at reset release is not seen as an edge.
  always_comb begin
    tick_d = tick_clk_i;
    tick_s = tick_clk_i & ~tick_q;
  end

  // Next-state, digit arithmetic and registered-output values.
  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    // Counting decisions use the pre-update state, so tick+start in RUN
    // still counts before pausing.
    count_s    = tick_s & (state_q == ST_RUN);

    if (clear_i) begin
      state_d    = ST_IDLE;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = start_i ? ST_RUN   : ST_IDLE;
        ST_RUN:   state_d = start_i ? ST_PAUSE : ST_RUN;
        ST_PAUSE: state_d = start_i ? ST_RUN   : ST_PAUSE;
        default:  state_d = ST_IDLE;
      endcase

      if (count_s) begin
        // ">=" rather than "==" so a corrupted digit is cleared on its
        // next carry instead of counting on through non-BCD codes.
        if (sec_ones_q >= ONES_LIM) begin
          sec_ones_d = 4'd0;
          if (sec_tens_q >= SEC_TENS_LIM) begin
            sec_tens_d = 4'd0;
            if (min_ones_q >= ONES_LIM) begin
              min_ones_d = 4'd0;
              if (min_tens_q >= MIN_TENS_LIM) begin
                min_tens_d = 4'd0;
                wrap_d     = 1'b1;
              end else begin
                min_tens_d = min_tens_q + 4'd1;
              end
            end else begin
              min_ones_d = min_ones_q + 4'd1;
            end
          end else begin
            sec_tens_d = sec_tens_q + 4'd1;
          end
        end else begin
          sec_ones_d = sec_ones_q + 4'd1;
        end
      end else begin
        wrap_d = 1'b0;
      end
    end

    // Registered from the next state so running_o matches state_q.
    running_d = (state_d == ST_RUN);
  end

  // State, digit and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tick_q     <= 1'b1;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  assign sec_ones_o = sec_ones_q;
  assign sec_tens_o = sec_tens_q;
  assign min_ones_o = min_ones_q;
  assign min_tens_o = min_tens_q;
  assign running_o  = running_q;
  assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_bcd
//   Directed self-checking bench for stopwatch_bcd. Inputs change 1 ns after
//   a rising clk_i edge and outputs are sampled at that same point, so each
//   call to cyc() is exactly one clock edge of DUT activity.
// ---------------------------------------------------------------------------
module tb_stopwatch_bcd;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       tick_clk_i = 1'b0;
  logic       start_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [3:0] sec_ones_o;
  logic [3:0] sec_tens_o;
  logic [3:0] min_ones_o;
  logic [3:0] min_tens_o;
  logic       running_o;
  logic       wrap_o;

  int tests_run = 0;
  int tests_failed = 0;

  stopwatch_bcd #(
    .MIN_TENS_MAX(5),
    .SEC_TENS_MAX(5)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tick_clk_i (tick_clk_i),
    .start_i    (start_i),
    .clear_i    (clear_i),
    .sec_ones_o (sec_ones_o),
    .sec_tens_o (sec_tens_o),
    .min_ones_o (min_ones_o),
    .min_tens_o (min_tens_o),
    .running_o  (running_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] digits();
    return {min_tens_o, min_ones_o, sec_tens_o, sec_ones_o};
  endfunction

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // One square-wave period: hi cycles high then lo cycles low. The count
  // edge is the first cycle of the high phase.
  task automatic tick_wave(input int hi, input int lo);
    tick_clk_i = 1'b1;
    cyc(hi);
    tick_clk_i = 1'b0;
    cyc(lo);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    tick_clk_i = 1'b1;
    rst_i = 1'b1;
    cyc(2);
    rst_i = 1'b0;
    tests_run++;
    if (digits() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_digits got %h want %h", digits(), 16'h0000);
    end
    tests_run++;
    if (running_o !== 1'b0 || wrap_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got run=%b wrap=%b want 0 0", running_o, wrap_o);
    end
    pulse_start();
    tests_run++;
    if (running_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_running got %b want 1", running_o);
    end
    cyc(20);
    tests_run++;
    if (digits() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL no_spurious_tick got %h want %h", digits(), 16'h0000);
    end
    tick_clk_i = 1'b0;
    cyc(4);
  endtask

  // Divider threshold 3: 4 cycles high, 4 low, one step every 8 clk_i.
  task automatic test_count10();
    for (int i = 0; i < 9; i++) tick_wave(4, 4);
    tests_run++;
    if (digits() !== 16'h0009) begin
      tests_failed++;
      $display("FAIL count9 got %h want %h", digits(), 16'h0009);
    end
    tick_clk_i = 1'b1;
    cyc();
    tests_run++;
    if (digits() !== 16'h0010) begin
      tests_failed++;
      $display("FAIL count10 got %h want %h", digits(), 16'h0010);
    end
    cyc(3);
    tick_clk_i = 1'b0;
    cyc(4);
  endtask

  task automatic test_wrap();
    pulse_clear();
    pulse_start();
    for (int i = 0; i < 59; i++) tick_wave(1, 1);
    tests_run++;
    if (digits() !== 16'h0059) begin
      tests_failed++;
      $display("FAIL preload_0059 got %h want %h", digits(), 16'h0059);
    end
    tick_clk_i = 1'b1;
    cyc();
    tests_run++;
    if (digits() !== 16'h0100 || wrap_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL minute_carry got %h wrap=%b want %h wrap=0", digits(), wrap_o, 16'h0100);
    end
    tick_clk_i = 1'b0;
    cyc();
    for (int i = 0; i < 3539; i++) tick_wave(1, 1);
    tests_run++;
    if (digits() !== 16'h5959 || wrap_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL at_5959 got %h wrap=%b want %h wrap=0", digits(), wrap_o, 16'h5959);
    end
    tick_clk_i = 1'b1;
    cyc();
    tests_run++;
    if (digits() !== 16'h0000 || wrap_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_edge got %h wrap=%b want %h wrap=1", digits(), wrap_o, 16'h0000);
    end
    tick_clk_i = 1'b0;
    cyc();
    tests_run++;
    if (wrap_o !== 1'b0 || running_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_one_cycle got wrap=%b run=%b want wrap=0 run=1", wrap_o, running_o);
    end
    tick_wave(1, 1);
    tests_run++;
    if (digits() !== 16'h0001) begin
      tests_failed++;
      $display("FAIL count_after_wrap got %h want %h", digits(), 16'h0001);
    end
  endtask

  task automatic test_pause();
    pulse_clear();
    pulse_start();
    for (int i = 0; i < 7; i++) tick_wave(2, 2);
    pulse_start();
    tests_run++;
    if (running_o !== 1'b0 || digits() !== 16'h0007) begin
      tests_failed++;
      $display("FAIL pause_enter got run=%b %h want run=0 %h", running_o, digits(), 16'h0007);
    end
    for (int i = 0; i < 5; i++) tick_wave(2, 2);
    tests_run++;
    if (digits() !== 16'h0007) begin
      tests_failed++;
      $display("FAIL pause_hold got %h want %h", digits(), 16'h0007);
    end
    pulse_start();
    tests_run++;
    if (running_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL resume got run=%b want 1", running_o);
    end
    tick_wave(2, 2);
    tests_run++;
    if (digits() !== 16'h0008) begin
      tests_failed++;
      $display("FAIL resume_count got %h want %h", digits(), 16'h0008);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    pulse_start();
    for (int i = 0; i < 3; i++) tick_wave(1, 1);
    tick_clk_i = 1'b1;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    tests_run++;
    if (digits() !== 16'h0004 || running_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL tick_start_run got %h run=%b want %h run=0", digits(), running_o, 16'h0004);
    end
    tick_clk_i = 1'b0;
    cyc();
    tick_clk_i = 1'b1;
    start_i = 1'b1;
    clear_i = 1'b1;
    cyc();
    start_i = 1'b0;
    clear_i = 1'b0;
    tests_run++;
    if (digits() !== 16'h0000 || running_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_priority got %h run=%b want %h run=0", digits(), running_o, 16'h0000);
    end
    tick_clk_i = 1'b0;
    cyc();
    tick_wave(1, 1);
    tests_run++;
    if (digits() !== 16'h0000 || running_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_hold got %h run=%b want %h run=0", digits(), running_o, 16'h0000);
    end
  endtask

  task automatic test_reset_midcount();
    pulse_clear();
    pulse_start();
    for (int i = 0; i < 754; i++) tick_wave(1, 1);
    tests_run++;
    if (digits() !== 16'h1234) begin
      tests_failed++;
      $display("FAIL reach_1234 got %h want %h", digits(), 16'h1234);
    end
    rst_i = 1'b1;
    tick_clk_i = 1'b1;
    start_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    start_i = 1'b0;
    tests_run++;
    if (digits() !== 16'h0000 || running_o !== 1'b0 || wrap_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midcount_reset got %h run=%b wrap=%b want 0000 0 0", digits(), running_o, wrap_o);
    end
    cyc(2);
    tests_run++;
    if (digits() !== 16'h0000 || running_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle got %h run=%b want 0000 0", digits(), running_o);
    end
    tick_clk_i = 1'b0;
    cyc();
    pulse_start();
    tick_wave(1, 1);
    tests_run++;
    if (digits() !== 16'h0001 || running_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart got %h run=%b want %h run=1", digits(), running_o, 16'h0001);
    end
  endtask

  initial begin
    cyc();
    test_reset();
    test_count10();
    test_wrap();
    test_pause();
    test_back_to_back();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
